// File: rtl/mssd_frame_scheduler_if.sv
// Bus between the four MSSD frame requesters and the frame scheduler.
// Requester i holds req[i] until it sees its one-cycle gnt[i]; done[i] marks the last bit sent.
interface mssd_frame_scheduler_if;
  logic [3:0]  req;
  logic [7:0]  dest;
  logic [15:0] len;
  logic [59:0] data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        serOut;
  logic        busy;

  modport master (
    output req, dest, len, data,
    input  gnt, done, serOut, busy
  );

  modport slave (
    input  req, dest, len, data,
    output gnt, done, serOut, busy
  );
endinterface

// File: rtl/mssd_frame_scheduler.sv
// Round-robin arbiter and serializer for the shared MSSD serial line.
// Frame: start 0, dest[1:0], len[3:0] MSB first, payload LSB first, then GAP idle-high cycles.
module mssd_frame_scheduler #(
  parameter int GAP = 2
) (
  input  logic                       Clk,
  input  logic                       reset,
  mssd_frame_scheduler_if.slave      bus,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  dest_sh_q, dest_sh_d;
  logic [3:0]  len_sh_q, len_sh_d;
  logic [15:0] data_sh_q, data_sh_d;

  logic        found;
  logic [1:0]  win_sel;
  logic [1:0]  idx;

  // Search starts at the pointer and wraps, so the last winner gets lowest priority.
  always_comb begin
    found   = 1'b0;
    win_sel = ptr_q;
    idx     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_sel = idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      dest_sh_q <= 2'd0;
      len_sh_q  <= 4'd0;
      data_sh_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      dest_sh_q <= dest_sh_d;
      len_sh_q  <= len_sh_d;
      data_sh_q <= data_sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    dest_sh_d = dest_sh_q;
    len_sh_d  = len_sh_q;
    data_sh_d = data_sh_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_START;
          bit_cnt_d = 4'd0;
          win_d     = win_sel;
          ptr_d     = win_sel + 2'd1;
          dest_sh_d = bus.dest[{win_sel, 1'b0} +: 2];
          len_sh_d  = bus.len[{win_sel, 2'b00} +: 4];
          data_sh_d = {1'b0, bus.data[6'(win_sel) * 6'd15 +: 15]};
        end
      end
      S_START: begin
        state_d   = S_ADDR;
        bit_cnt_d = 4'd0;
      end
      S_ADDR: begin
        if (bit_cnt_q == 4'd1) begin
          state_d   = S_LEN;
          bit_cnt_d = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_LEN: begin
        if (bit_cnt_q == 4'd3) begin
          state_d   = (len_sh_q != 4'd0) ? S_DATA : S_GAP;
          bit_cnt_d = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == len_sh_q - 4'd1) begin
          state_d   = S_GAP;
          bit_cnt_d = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (bit_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          bit_cnt_d = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  // Outputs decode purely from registered state, so reset forces the line high at once.
  always_comb begin
    bus.serOut = 1'b1;
    bus.gnt    = 4'd0;
    bus.done   = 4'd0;
    bus.busy   = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  bus.serOut = 1'b1;
      S_START: begin
        bus.serOut = 1'b0;
        bus.gnt    = 4'd1 << win_q;
      end
      S_ADDR:  bus.serOut = dest_sh_q[~bit_cnt_q[0]];
      S_LEN:   bus.serOut = len_sh_q[~bit_cnt_q[1:0]];
      S_DATA:  bus.serOut = data_sh_q[bit_cnt_q];
      S_GAP: begin
        bus.serOut = 1'b1;
        if (bit_cnt_q == 4'd0) bus.done = 4'd1 << win_q;
      end
      default: bus.serOut = 1'b1;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mssd_frame_scheduler.sv
// Directed bench for mssd_frame_scheduler: frame format, round-robin order, mid-frame isolation, reset abort.
module tb_mssd_frame_scheduler;
  localparam int GAP = 2;

  logic       Clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_gnt_cyc = 0;
  int         gnt_gap = 0;
  logic [0:0] exp_q[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  mssd_frame_scheduler_if bus();

  mssd_frame_scheduler #(.GAP(GAP)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic set_req(input int i, input logic [1:0] d, input logic [3:0] l, input logic [14:0] dat);
    bus.dest[2*i +: 2]  = d;
    bus.len[4*i +: 4]   = l;
    bus.data[15*i +: 15] = dat;
  endtask

  // Called at the negedge of the expected START cycle; returns at the following IDLE cycle.
  task automatic expect_frame(input int win, input logic [1:0] d, input logic [3:0] l,
                              input logic [14:0] dat, input bit keep, input bit mutate);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << win;
    exp_q = {};
    exp_q.push_back(1'b0);
    exp_q.push_back(d[1]);
    exp_q.push_back(d[0]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(l[b]);
    for (int k = 0; k < int'(l); k++) exp_q.push_back(dat[k]);
    for (int g = 0; g < GAP; g++) exp_q.push_back(1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("r%0d_c%0d_serOut", win, i), 64'(bus.serOut), 64'(exp_q[i]));
      chk($sformatf("r%0d_c%0d_gnt", win, i), 64'(bus.gnt), (i == 0) ? 64'(oh) : 64'd0);
      chk($sformatf("r%0d_c%0d_done", win, i), 64'(bus.done), (i == 7 + int'(l)) ? 64'(oh) : 64'd0);
      chk($sformatf("r%0d_c%0d_busy", win, i), 64'(bus.busy), 64'd1);
      if (i == 0) begin
        gnt_gap = cyc - last_gnt_cyc;
        last_gnt_cyc = cyc;
        if (!keep) bus.req[win] = 1'b0;
      end
      if (mutate && i == 8) begin
        bus.data[15*win +: 15] = ~dat;
        bus.len[4*win +: 4]    = ~l;
        bus.dest[2*win +: 2]   = ~d;
        bus.req[3]             = 1'b1;
      end
      tick();
    end
    chk($sformatf("r%0d_idle_busy", win), 64'(bus.busy), 64'd0);
    chk($sformatf("r%0d_idle_serOut", win), 64'(bus.serOut), 64'd1);
    chk($sformatf("r%0d_idle_gnt", win), 64'(bus.gnt), 64'd0);
    chk($sformatf("r%0d_idle_done", win), 64'(bus.done), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    bus.req  = 4'd0;
    bus.dest = 8'd0;
    bus.len  = 16'd0;
    bus.data = 60'd0;
    tick();
    tick();
    chk("rst_serOut", 64'(bus.serOut), 64'd1);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_no_req_busy", 64'(bus.busy), 64'd0);

    // Requester 0: dest 2, len 3, data ..101 -> 0,1,0,0,0,1,1,1,0,1,1,1
    set_req(0, 2'd2, 4'd3, 15'b000_0000_0000_0101);
    bus.req = 4'b0001;
    tick();
    chk("t1_first_bit", 64'(bus.serOut), 64'd0);
    expect_frame(0, 2'd2, 4'd3, 15'b000_0000_0000_0101, 1'b0, 1'b0);

    // Requester 2: empty payload, done 7 cycles after gnt
    set_req(2, 2'd3, 4'd0, 15'h7fff);
    bus.req = 4'b0100;
    tick();
    expect_frame(2, 2'd3, 4'd0, 15'h7fff, 1'b0, 1'b0);

    // Round-robin with all four held, pointer cleared by reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 2'd1, 4'd1, 15'h0001);
    set_req(1, 2'd2, 4'd1, 15'h0000);
    set_req(2, 2'd3, 4'd1, 15'h0001);
    set_req(3, 2'd0, 4'd1, 15'h0000);
    bus.req = 4'b1111;
    tick();
    expect_frame(0, 2'd1, 4'd1, 15'h0001, 1'b1, 1'b0);
    tick();
    expect_frame(1, 2'd2, 4'd1, 15'h0000, 1'b1, 1'b0);
    chk("rr_spacing_01", 64'(gnt_gap), 64'd11);
    tick();
    expect_frame(2, 2'd3, 4'd1, 15'h0001, 1'b1, 1'b0);
    chk("rr_spacing_12", 64'(gnt_gap), 64'd11);
    tick();
    expect_frame(3, 2'd0, 4'd1, 15'h0000, 1'b1, 1'b0);
    chk("rr_spacing_23", 64'(gnt_gap), 64'd11);
    tick();
    expect_frame(0, 2'd1, 4'd1, 15'h0001, 1'b1, 1'b0);
    chk("rr_spacing_30", 64'(gnt_gap), 64'd11);
    bus.req = 4'b0000;
    tick();
    chk("rr_idle_after_drop", 64'(bus.busy), 64'd0);

    // Serve 1 so the pointer sits at 2, then 0 and 1 together: wrap picks 0 first
    bus.req = 4'b0010;
    tick();
    expect_frame(1, 2'd2, 4'd1, 15'h0000, 1'b0, 1'b0);
    bus.req = 4'b0011;
    tick();
    expect_frame(0, 2'd1, 4'd1, 15'h0001, 1'b0, 1'b0);
    tick();
    expect_frame(1, 2'd2, 4'd1, 15'h0000, 1'b0, 1'b0);

    // Inputs changed during DATA must not alter the frame; req3 waits for GAP+IDLE
    set_req(1, 2'd1, 4'd8, 15'b000_0000_1011_0010);
    set_req(3, 2'd2, 4'd2, 15'b000_0000_0000_0010);
    bus.req = 4'b0010;
    tick();
    expect_frame(1, 2'd1, 4'd8, 15'b000_0000_1011_0010, 1'b0, 1'b1);
    tick();
    expect_frame(3, 2'd2, 4'd2, 15'b000_0000_0000_0010, 1'b0, 1'b0);

    // Reset in LEN phase: line high next cycle, no done, pointer back to 0
    set_req(1, 2'd1, 4'd4, 15'h0005);
    bus.req = 4'b0010;
    tick();
    chk("ab_gnt", 64'(bus.gnt), 64'b0010);
    chk("ab_start", 64'(bus.serOut), 64'd0);
    bus.req = 4'b0000;
    tick();
    chk("ab_addr1", 64'(bus.serOut), 64'd0);
    tick();
    chk("ab_addr0", 64'(bus.serOut), 64'd1);
    tick();
    chk("ab_len3", 64'(bus.serOut), 64'd0);
    tick();
    chk("ab_len2", 64'(bus.serOut), 64'd1);
    reset = 1'b1;
    tick();
    chk("ab_rst_serOut", 64'(bus.serOut), 64'd1);
    chk("ab_rst_busy", 64'(bus.busy), 64'd0);
    chk("ab_rst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ab_post_done_%0d", i), 64'(bus.done), 64'd0);
      chk($sformatf("ab_post_serOut_%0d", i), 64'(bus.serOut), 64'd1);
    end
    set_req(0, 2'd0, 4'd2, 15'h0003);
    set_req(3, 2'd3, 4'd3, 15'h0002);
    bus.req = 4'b1001;
    tick();
    expect_frame(0, 2'd0, 4'd2, 15'h0003, 1'b0, 1'b0);
    tick();
    expect_frame(3, 2'd3, 4'd3, 15'h0002, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
